// File: rtl/mux_nx1_rr.sv
// N:1 stream multiplexer with explicit-select or round-robin channel choice
// and a one-entry registered output stage (one cycle latency, full throughput).
module mux_nx1_rr #(
  parameter  int N  = 8,
  parameter  int W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_ch
);

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_out_ch;
  logic [SW-1:0] r_ptr;

  logic          w_rr_found;
  logic [SW-1:0] w_rr_idx;
  logic [SW-1:0] w_rr_pos;
  logic          w_sel_ok;
  logic          w_grant_any;
  logic [SW-1:0] w_grant_idx;
  logic          w_load_en;
  logic          w_take;
  logic [SW-1:0] w_ptr_next;
  logic [W-1:0]  w_sel_data;

  // Round-robin search starts at ptr and wraps; first valid channel wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_rr_pos = SW'((int'(r_ptr) + k) % N);
      if (!w_rr_found && in_valid[w_rr_pos]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_pos;
      end
    end
  end

  assign w_sel_ok    = (int'(sel) < N) && in_valid[sel];
  assign w_grant_any = mode ? w_rr_found : w_sel_ok;
  assign w_grant_idx = mode ? w_rr_idx : sel;

  // The output slot can accept a word when empty or draining this cycle.
  assign w_load_en = !r_out_valid || out_ready;
  assign w_take    = w_load_en && w_grant_any && !rst;

  assign w_ptr_next = (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + SW'(1);

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant_idx == SW'(k)) begin
        w_sel_data = in_data[k*W +: W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = w_take && (int'(w_grant_idx) == gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_take) begin
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_grant_idx;
        r_out_valid <= 1'b1;
        if (mode) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr (N=8, W=3): table of per-cycle vectors plus hand-built
// backpressure and mid-operation reset sequences, checked through a queue.
module tb_mux_nx1_rr;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int SW = 3;

  logic            clk;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;

  mux_nx1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic           ordy;
    logic [N-1:0]   exp_rdy;
    logic           exp_ov;
    logic [SW-1:0]  exp_ch;
    logic [W-1:0]   exp_od;
  } vec_t;

  typedef struct {
    logic          ov;
    logic [SW-1:0] ch;
    logic [W-1:0]  od;
    int            id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [N*W-1:0] data_idx();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(i);
    return d;
  endfunction

  function automatic logic [N*W-1:0] data_onehot(input int k);
    logic [N*W-1:0] d;
    d = '0;
    d[k*W +: W] = W'(1);
    return d;
  endfunction

  function automatic vec_t mk(input logic r, input logic m, input logic [SW-1:0] s,
                              input logic [N-1:0] v, input logic [N*W-1:0] d,
                              input logic o, input logic [N-1:0] er,
                              input logic eov, input logic [SW-1:0] ech,
                              input logic [W-1:0] eod);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.data = d; t.ordy = o;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_ch = ech; t.exp_od = eod;
    return t;
  endfunction

  // Called at posedge+1: drive, check combinational ready, then check outputs after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t g;
    rst = v.rst; mode = v.mode; sel = v.sel; in_valid = v.valid;
    in_data = v.data; out_ready = v.ordy;
    #3;
    if (in_ready !== v.exp_rdy) begin
      n_miss++;
      $display("FAIL in_ready vec%0d: got %b want %b", n_vec, in_ready, v.exp_rdy);
    end
    e.ov = v.exp_ov; e.ch = v.exp_ch; e.od = v.exp_od; e.id = n_vec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    if (out_valid !== g.ov || out_ch !== g.ch || out_data !== g.od) begin
      n_miss++;
      $display("FAIL out_word vec%0d: got v=%b ch=%0d d=%0d want v=%b ch=%0d d=%0d",
               g.id, out_valid, out_ch, out_data, g.ov, g.ch, g.od);
    end
    $display("vec%0d rst=%b mode=%b sel=%0d valid=%h ordy=%b -> rdy=%h ov=%b ch=%0d d=%0d",
             n_vec, v.rst, v.mode, v.sel, v.valid, v.ordy, in_ready, out_valid, out_ch, out_data);
    n_vec++;
  endtask

  initial begin
    logic [N*W-1:0] di;
    di = data_idx();
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; in_data = di; out_ready = 1'b1;

    // Reset held two cycles with everything valid, then release in round-robin mode.
    vecs.push_back(mk(1, 1, 0, 8'hFF, di, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'hFF, di, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hFF, di, 1, 8'h01, 1, 0, 0));
    // Explicit select sweep.
    for (int k = 0; k < N; k++)
      vecs.push_back(mk(0, 0, SW'(k), 8'hFF, data_onehot(k), 1, N'(1) << k, 1, SW'(k), 3'd1));
    // Selected channel not valid: no fallback, output empties, word held.
    vecs.push_back(mk(0, 0, 3, 8'hF7, di, 1, 8'h00, 0, 7, 1));
    // Re-reset so fairness starts at channel 0.
    vecs.push_back(mk(1, 1, 0, 8'hFF, di, 1, 8'h00, 0, 0, 0));
    for (int j = 0; j < 10; j++)
      vecs.push_back(mk(0, 1, 0, 8'hFF, di, 1, N'(1) << (j % N), 1, SW'(j % N), W'(j % N)));
    // ptr is 2; one grant on channel 2 brings it to 3, then the sparse pattern.
    vecs.push_back(mk(0, 1, 0, 8'h04, di, 1, 8'h04, 1, 2, 2));
    vecs.push_back(mk(0, 1, 0, 8'h24, di, 1, 8'h20, 1, 5, 5));
    vecs.push_back(mk(0, 1, 0, 8'h24, di, 1, 8'h04, 1, 2, 2));
    vecs.push_back(mk(0, 1, 0, 8'h00, di, 1, 8'h00, 0, 2, 2));

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // Backpressure: load channel 4, stall three cycles with changing inputs, then drain+refill.
    apply(mk(0, 0, 4, 8'hFF, di, 1, 8'h10, 1, 4, 4));
    apply(mk(0, 1, 0, 8'hFF, di, 0, 8'h00, 1, 4, 4));
    apply(mk(0, 0, 2, 8'h0F, di, 0, 8'h00, 1, 4, 4));
    apply(mk(0, 1, 7, 8'hA5, data_onehot(1), 0, 8'h00, 1, 4, 4));
    apply(mk(0, 0, 6, 8'hFF, di, 1, 8'h40, 1, 6, 6));

    // Reset mid-operation with ptr=6 and a stalled word.
    apply(mk(0, 1, 0, 8'h20, di, 1, 8'h20, 1, 5, 5));
    apply(mk(0, 1, 0, 8'hFF, di, 0, 8'h00, 1, 5, 5));
    apply(mk(1, 1, 0, 8'hFF, di, 0, 8'h00, 0, 0, 0));
    apply(mk(0, 1, 0, 8'h48, di, 1, 8'h08, 1, 3, 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N:1 channel multiplexer with per-channel valid/ready handshakes and a registered output stage. It extends the combinational 8:1 select mux to N channels of W bits. Channel choice is either explicit (select input) or round-robin arbitration across valid channels. It sits between multiple producer streams and one consumer, giving one cycle of latency and full throughput.

## Interface
- N, default 8: number of input channels, N ≥ 2.
- W, default 1: data width per channel, W ≥ 1.
- SW, default $clog2(N): select/channel-index width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Synchronous and active-high.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready (combinational).
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SW  channel index, used when mode=0.
- out_data  out  W  registered selected data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the output word.
- out_ch  out  SW  index of the channel that supplied out_data.

## Operation
- One-entry output register: out_data, out_ch, out_valid.
- load_en = !out_valid | out_ready. This allows a pass-through refill on the same cycle as a drain.
- Grant vector g (one-hot or zero) is computed every cycle:
  - mode=0: g[sel]=1 iff in_valid[sel]=1 and sel < N. Otherwise g=0. No fallback to other channels.
  - mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. g=0 if no channel is valid.
- in_ready = g when load_en=1, else all zero. At most one in_ready bit is high per cycle.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On the next edge: out_data ← channel i data, out_ch ← i, out_valid ← 1.
- If load_en=1 and g=0: out_valid ← 0. out_data and out_ch hold their last values.
- If out_valid=1 and out_ready=0: out_data and out_ch are held stable, in_ready stays all zero, and no channel is dropped.
- Round-robin pointer ptr (SW bits):
  - On a mode=1 transfer from channel i, ptr ← (i+1) mod N. Wrap-around applies at i = N-1, giving ptr ← 0.
  - Unchanged on mode=0 transfers and on idle cycles.
- mode and sel are sampled every cycle. A change takes effect on the same cycle's grant. No in-flight word is affected.

## Timing
- Reset values (after any clk edge with rst=1): out_valid=0, out_data=0, out_ch=0, ptr=0.
- While rst=1, in_ready is forced to all zero.
- rst has priority over every transfer in the same cycle.
- Reset mid-operation discards the held word. No transfer is acknowledged in the reset cycle.
- Latency: transfer at edge k gives out_valid=1 with that data after edge k.
- Throughput: one word per cycle while out_ready=1 and a granted channel is valid.
- in_ready depends combinationally on in_valid, mode, sel, ptr, out_valid and out_ready. Producers must not make in_valid depend on in_ready.
- An output word transfers on any edge with out_valid & out_ready.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=8'hFF, out_ready=1 → in_ready=0, out_valid=0, out_data=0, out_ch=0. Release rst → in_ready=8'h01 (mode=1).
- Explicit select sweep (N=8, W=1, mode=0, out_ready=1): for k=0..7 drive a one-hot data word with bit k=1, all channels valid, sel=k → one cycle later out_data=1, out_ch=k. Then sel=3 with in_valid[3]=0 → in_ready=0, out_valid drops to 0.
- Round-robin fairness (W=3, channel i data=i, all valid, mode=1, out_ready=1) → out_ch/out_data sequence 0,1,2,…,7,0,1 on consecutive cycles, one in_ready bit high per cycle.
- Sparse round-robin: ptr=3, in_valid=8'b0010_0100 → grant 5 first (ptr→6), then grant 2 (ptr→3), then idle with out_valid=0.
- Backpressure: out_valid=1, out_ch=4, out_ready=0 for 3 cycles while inputs change → out_data/out_ch stable and in_ready=0. On out_ready=1, the word drains and the next grant loads in the same cycle.
- Reset mid-operation: rst=1 while out_valid=1, out_ready=0, ptr=6 → next cycle out_valid=0, ptr=0. The first post-reset mode=1 grant is the lowest valid index.
